// File: rtl/cregister_pipe_if.sv
// Stream bundle for cregister_pipe: producer side, consumer side, flush and occupancy.
// Latency: none, wires only.
// Backpressure: in_ready/out_ready carry the valid/ready handshake in each direction.
interface cregister_pipe_if #(
  parameter int DATAWIDTH = 8,
  parameter int DEPTH     = 2
);
  // One extra code point so a skid-extended pipe (DEPTH+1 words) still fits.
  localparam int OCCW = $clog2(DEPTH + 2);

  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [DATAWIDTH-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATAWIDTH-1:0] out_data;
  logic [OCCW-1:0]      occupancy;

  // Environment side: drives the producer word, consumer ready and flush.
  modport master (
    output flush,
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  occupancy
  );

  // Pipeline side.
  modport slave (
    input  flush,
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output occupancy
  );
endinterface

// File: rtl/cregister_pipe.sv
// Elastic DEPTH-stage valid/ready register pipeline with bubble collapsing, flush and occupancy.
// Latency: DEPTH cycles from accept to out_* when unstalled; one word per cycle throughput.
// Backpressure: stalled output lets upstream bubbles fill; in_ready drops only when every slot is held.
// Optional feature macro: CREGISTER_PIPE_SKID_EN adds a skid register after the last stage
// (capacity DEPTH+1, in_ready no longer combinationally depends on out_ready).
module cregister_pipe #(
  parameter int DATAWIDTH = 8,
  parameter int DEPTH     = 2
) (
  input  logic             clk,
  input  logic             reset,
  cregister_pipe_if.slave  bus
);

  // Fixed from DEPTH; must agree with the width carried by the interface instance.
  localparam int OCCW = $clog2(DEPTH + 2);

  // Per-stage state: stage 0 is fed from the input, stage DEPTH-1 faces the consumer.
  logic [DEPTH-1:0]     valid_q;
  logic [DATAWIDTH-1:0] data_q [DEPTH];

  // What each stage would load if it is allowed to move this cycle.
  logic [DEPTH-1:0]     feed_valid;
  logic [DATAWIDTH-1:0] feed_data [DEPTH];

  // ready[i]: stage i may load this cycle (it is empty or its word moves on).
  logic [DEPTH-1:0]     ready;
  // Readiness of whatever sits after the last stage (consumer or skid register).
  logic                 ready_end;

  logic                 in_ready_w;
  logic                 accept;
  logic                 transfer;
  logic                 out_valid_w;
  logic [DATAWIDTH-1:0] out_data_w;
  logic                 valid_last;
  logic [DATAWIDTH-1:0] data_last;

  logic [OCCW-1:0]      occ_q;

  assign valid_last = valid_q[DEPTH-1];
  assign data_last  = data_q[DEPTH-1];

  // Ready ripples back from the output: a stage is ready if it is empty or everything ahead can move.
  always_comb begin
    logic chain;
    ready = '0;
    chain = ready_end;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      chain    = ~valid_q[i] | chain;
      ready[i] = chain;
    end
  end

  // Never accept during reset or flush so a flushed pipe starts truly empty.
  assign in_ready_w = ready[0] & ~bus.flush & ~reset;
  assign accept     = bus.in_valid & in_ready_w;
  assign transfer   = out_valid_w & bus.out_ready;

  // Source of each stage: the accepted input word for stage 0, the previous stage otherwise.
  always_comb begin
    feed_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      feed_data[i] = '0;
    end
    feed_valid[0] = accept;
    feed_data[0]  = bus.in_data;
    for (int i = 1; i < DEPTH; i++) begin
      feed_valid[i] = valid_q[i-1];
      feed_data[i]  = data_q[i-1];
    end
  end

  // Stage valids: move when ready, hold otherwise; flush empties every stage at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (bus.flush) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ready[i]) begin
          valid_q[i] <= feed_valid[i];
        end
      end
    end
  end

  // Stage data: only load real words, so a stage keeps its last word when a bubble passes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ready[i] && feed_valid[i]) begin
          data_q[i] <= feed_data[i];
        end
      end
    end
  end

`ifdef CREGISTER_PIPE_SKID_EN
  // Skid slot: catches the last stage's word when the consumer stalls, so the
  // pipeline's ready chain depends only on registered state.
  logic                 skid_valid;
  logic [DATAWIDTH-1:0] skid_data;

  assign ready_end   = ~skid_valid;
  assign out_valid_w = skid_valid | valid_last;
  assign out_data_w  = skid_valid ? skid_data : data_last;

  // Skid fills on a stalled last-stage word and drains first once the consumer takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (bus.flush) begin
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (bus.out_ready) begin
        skid_valid <= 1'b0;
      end
    end else if (valid_last && !bus.out_ready) begin
      skid_valid <= 1'b1;
      skid_data  <= data_last;
    end
  end
`else
  // Without a skid slot the consumer's ready feeds the ready chain directly.
  assign ready_end   = bus.out_ready;
  assign out_valid_w = valid_last;
  assign out_data_w  = data_last;
`endif

  // Occupancy tracks words held: +1 per accept, -1 per transfer, cleared by flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q <= '0;
    end else if (bus.flush) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_q + OCCW'(accept) - OCCW'(transfer);
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.out_data  = out_data_w;
  assign bus.occupancy = occ_q;

endmodule
